// File: rtl/reg_bank_pkg.sv
// reg_bank_pkg: shared definitions for the register bank.
//   wr_op_e     : write-port operation encoding (load / add / subtract / increment)
//   clr_state_e : bulk-clear sequencer states
package reg_bank_pkg;

  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_ADD  = 2'b01,
    OP_SUB  = 2'b10,
    OP_INC  = 2'b11
  } wr_op_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_e;

endpackage

// File: rtl/reg_bank_clr_fsm.sv
// reg_bank_clr_fsm: bulk-clear sequencer. Walks cnt from 0 to DEPTH-1, one
// entry per falling edge, after a clr_start seen in IDLE.
// Ports:
//   clk       in  clock (state updates on falling edge)
//   reset     in  synchronous active-high reset, abandons any clear in progress
//   hold      in  freezes state and counter
//   clr_start in  starts a clear when idle; ignored while clearing
//   busy      out high while in CLEAR
//   clr_en    out the coming edge clears entry clr_addr
//   clr_addr  out entry cleared on the coming edge
module reg_bank_clr_fsm
  import reg_bank_pkg::*;
#(
  parameter  int DEPTH  = 4,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hold,
  input  logic              clr_start,
  output logic              busy,
  output logic              clr_en,
  output logic [ADDR_W-1:0] clr_addr
);

  clr_state_e        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!hold) begin
      case (state_q)
        ST_IDLE: begin
          if (clr_start) begin
            state_d = ST_CLEAR;
            cnt_d   = '0;
          end
        end
        ST_CLEAR: begin
          // DEPTH is a power of two, so the counter wraps back to 0 by itself.
          cnt_d = cnt_q + ADDR_W'(1);
          if (cnt_q == ADDR_W'(DEPTH - 1)) state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(negedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy     = (state_q == ST_CLEAR);
  assign clr_en   = busy && !hold;
  assign clr_addr = cnt_q;

endmodule

// File: rtl/reg_bank.sv
// reg_bank: DEPTH x WIDTH register bank with an arithmetic write port, two
// combinational read ports and a sequenced bulk-clear engine.
// Ports:
//   clk, reset              falling-edge clock, synchronous active-high reset
//   hold                    freezes all state; writes under hold are ignored silently
//   wr_en/wr_op/wr_addr/wr_data  write request (load/add/sub/inc)
//   rd_addr_a/rd_data_a     read port A (combinational, no write-through)
//   rd_addr_b/rd_data_b     read port B (combinational, no write-through)
//   clr_start, busy         bulk-clear start and in-progress flag
//   ovf                     carry/borrow of the last accepted arithmetic write
//   wr_drop                 one-cycle pulse when a write was rejected by the clear engine
//   regs_flat               all entries, entry i at [i*WIDTH +: WIDTH]
module reg_bank
  import reg_bank_pkg::*;
#(
  parameter  int WIDTH  = 8,
  parameter  int DEPTH  = 4,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   hold,
  input  logic                   wr_en,
  input  logic [1:0]             wr_op,
  input  logic [ADDR_W-1:0]      wr_addr,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic [ADDR_W-1:0]      rd_addr_a,
  output logic [WIDTH-1:0]       rd_data_a,
  input  logic [ADDR_W-1:0]      rd_addr_b,
  output logic [WIDTH-1:0]       rd_data_b,
  input  logic                   clr_start,
  output logic                   busy,
  output logic                   ovf,
  output logic                   wr_drop,
  output logic [DEPTH*WIDTH-1:0] regs_flat
);

  logic [WIDTH-1:0]  regs_q [DEPTH];
  logic [WIDTH-1:0]  regs_d [DEPTH];
  logic              ovf_q, ovf_d;
  logic              drop_q, drop_d;
  logic              clr_en;
  logic [ADDR_W-1:0] clr_addr;
  logic              wr_ok;
  logic [WIDTH:0]    alu_res;

  // Result MSB is the carry-out for add/inc and the borrow for subtract.
  function automatic logic [WIDTH:0] alu_op(input wr_op_e op,
                                            input logic [WIDTH-1:0] a,
                                            input logic [WIDTH-1:0] b);
    case (op)
      OP_LOAD: return {1'b0, b};
      OP_ADD:  return {1'b0, a} + {1'b0, b};
      OP_SUB:  return {1'b0, a} - {1'b0, b};
      default: return {1'b0, a} + (WIDTH+1)'(1);
    endcase
  endfunction

  reg_bank_clr_fsm #(.DEPTH(DEPTH)) u_clr (
    .clk      (clk),
    .reset    (reset),
    .hold     (hold),
    .clr_start(clr_start),
    .busy     (busy),
    .clr_en   (clr_en),
    .clr_addr (clr_addr)
  );

  assign alu_res = alu_op(wr_op_e'(wr_op), regs_q[wr_addr], wr_data);
  // A clear that is running or about to start owns the array this edge.
  assign wr_ok   = wr_en && !hold && !busy && !clr_start;

  always_comb begin
    regs_d = regs_q;
    ovf_d  = ovf_q;
    drop_d = 1'b0;
    if (!hold) begin
      drop_d = wr_en && (busy || clr_start);
      if (clr_en) begin
        regs_d[clr_addr] = '0;
      end else if (wr_ok) begin
        regs_d[wr_addr] = alu_res[WIDTH-1:0];
        ovf_d           = alu_res[WIDTH];
      end
    end
  end

  always_ff @(negedge clk) begin
    if (reset) begin
      regs_q <= '{default: '0};
      ovf_q  <= 1'b0;
      drop_q <= 1'b0;
    end else begin
      regs_q <= regs_d;
      ovf_q  <= ovf_d;
      drop_q <= drop_d;
    end
  end

  assign rd_data_a = regs_q[rd_addr_a];
  assign rd_data_b = regs_q[rd_addr_b];
  assign ovf       = ovf_q;
  assign wr_drop   = drop_q;

  for (genvar i = 0; i < DEPTH; i++) begin : g_flat
    assign regs_flat[i*WIDTH +: WIDTH] = regs_q[i];
  end

endmodule

// File: tb/tb_reg_bank.sv
module tb_reg_bank;
  import reg_bank_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance 0: WIDTH=8 DEPTH=4; instance 1: WIDTH=16 DEPTH=8
  logic        rst_s [2], hold_s [2], wen_s [2], clr_s [2];
  logic [1:0]  op_s  [2];
  logic [2:0]  wa_s  [2], ra_s [2], rb_s [2];
  logic [15:0] wd_s  [2];

  logic [7:0]   rda0, rdb0;
  logic [31:0]  flat0;
  logic         busy0, ovf0, drop0;
  logic [15:0]  rda1, rdb1;
  logic [127:0] flat1;
  logic         busy1, ovf1, drop1;

  reg_bank #(.WIDTH(8), .DEPTH(4)) u0 (
    .clk(clk), .reset(rst_s[0]), .hold(hold_s[0]), .wr_en(wen_s[0]), .wr_op(op_s[0]),
    .wr_addr(wa_s[0][1:0]), .wr_data(wd_s[0][7:0]), .rd_addr_a(ra_s[0][1:0]), .rd_data_a(rda0),
    .rd_addr_b(rb_s[0][1:0]), .rd_data_b(rdb0), .clr_start(clr_s[0]), .busy(busy0),
    .ovf(ovf0), .wr_drop(drop0), .regs_flat(flat0));

  reg_bank #(.WIDTH(16), .DEPTH(8)) u1 (
    .clk(clk), .reset(rst_s[1]), .hold(hold_s[1]), .wr_en(wen_s[1]), .wr_op(op_s[1]),
    .wr_addr(wa_s[1]), .wr_data(wd_s[1]), .rd_addr_a(ra_s[1]), .rd_data_a(rda1),
    .rd_addr_b(rb_s[1]), .rd_data_b(rdb1), .clr_start(clr_s[1]), .busy(busy1),
    .ovf(ovf1), .wr_drop(drop1), .regs_flat(flat1));

  typedef struct {
    logic [127:0] flat;
    logic         ovf, drop, busy;
    logic [15:0]  rda, rdb;
  } exp_t;

  exp_t q0[$], q1[$];
  int   n_tests = 0, n_fail = 0;

  // Reference model state
  int W [2] = '{8, 16};
  int D [2] = '{4, 8};
  int m_reg [2][8];
  bit m_ovf [2], m_drop [2], m_busy [2];
  int m_cnt [2];

  // Pending stimulus for the next edge
  bit s_rst [2], s_hold [2], s_wen [2], s_clr [2];
  int s_op [2], s_wa [2], s_wd [2], s_ra [2], s_rb [2];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic model(input int k);
    int mask;
    bit acc;
    int r, b;
    mask = (1 << W[k]) - 1;
    if (s_rst[k]) begin
      for (int i = 0; i < 8; i++) m_reg[k][i] = 0;
      m_ovf[k] = 0; m_drop[k] = 0; m_busy[k] = 0; m_cnt[k] = 0;
    end else if (s_hold[k]) begin
      m_drop[k] = 0;
    end else begin
      acc = s_wen[k] && !m_busy[k] && !s_clr[k];
      m_drop[k] = s_wen[k] && !acc;
      if (m_busy[k]) begin
        m_reg[k][m_cnt[k]] = 0;
        m_cnt[k]++;
        if (m_cnt[k] == D[k]) begin
          m_busy[k] = 0;
          m_cnt[k] = 0;
        end
      end else if (s_clr[k]) begin
        m_busy[k] = 1;
        m_cnt[k] = 0;
      end
      if (acc) begin
        r = m_reg[k][s_wa[k]];
        b = s_wd[k] & mask;
        case (s_op[k])
          0: begin r = b; m_ovf[k] = 0; end
          1: begin r = r + b; m_ovf[k] = (r > mask); end
          2: begin m_ovf[k] = (b > r); r = r - b; end
          default: begin r = r + 1; m_ovf[k] = (r > mask); end
        endcase
        m_reg[k][s_wa[k]] = r & mask;
      end
    end
  endtask

  function automatic exp_t snapshot(input int k);
    exp_t e;
    e.flat = '0;
    for (int i = 0; i < D[k]; i++) e.flat |= (128'(m_reg[k][i]) << (i * W[k]));
    e.ovf  = m_ovf[k];
    e.drop = m_drop[k];
    e.busy = m_busy[k];
    e.rda  = 16'(m_reg[k][s_ra[k]]);
    e.rdb  = 16'(m_reg[k][s_rb[k]]);
    return e;
  endfunction

  task automatic idle_defaults();
    for (int k = 0; k < 2; k++) begin
      s_rst[k] = 0; s_hold[k] = 0; s_wen[k] = 0; s_clr[k] = 0;
      s_op[k] = 0; s_wa[k] = 0; s_wd[k] = 0;
      s_ra[k] = $urandom_range(0, D[k] - 1);
      s_rb[k] = $urandom_range(0, D[k] - 1);
    end
  endtask

  task automatic apply();
    for (int k = 0; k < 2; k++) begin
      rst_s[k] = s_rst[k]; hold_s[k] = s_hold[k]; wen_s[k] = s_wen[k]; clr_s[k] = s_clr[k];
      op_s[k] = 2'(s_op[k]); wa_s[k] = 3'(s_wa[k]); wd_s[k] = 16'(s_wd[k]);
      ra_s[k] = 3'(s_ra[k]); rb_s[k] = 3'(s_rb[k]);
    end
  endtask

  // Drives one falling edge worth of stimulus and queues the expected outcome.
  task automatic tick();
    @(posedge clk);
    #1;
    apply();
    for (int k = 0; k < 2; k++) model(k);
    q0.push_back(snapshot(0));
    q1.push_back(snapshot(1));
    idle_defaults();
  endtask

  task automatic wr(input int k, input wr_op_e op, input int addr, input int data, input bit hld = 0);
    s_wen[k] = 1; s_op[k] = int'(op); s_wa[k] = addr; s_wd[k] = data; s_hold[k] = hld;
    s_ra[k] = addr; s_rb[k] = addr;
    tick();
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  // Monitor: every rising edge the outputs reflect the previous falling edge.
  always @(posedge clk) begin
    exp_t e;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      chk("u0.flat", 128'(flat0), e.flat);
      chk("u0.ovf", 128'(ovf0), 128'(e.ovf));
      chk("u0.drop", 128'(drop0), 128'(e.drop));
      chk("u0.busy", 128'(busy0), 128'(e.busy));
      chk("u0.rda", 128'(rda0), 128'(e.rda));
      chk("u0.rdb", 128'(rdb0), 128'(e.rdb));
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      chk("u1.flat", flat1, e.flat);
      chk("u1.ovf", 128'(ovf1), 128'(e.ovf));
      chk("u1.drop", 128'(drop1), 128'(e.drop));
      chk("u1.busy", 128'(busy1), 128'(e.busy));
      chk("u1.rda", 128'(rda1), 128'(e.rda));
      chk("u1.rdb", 128'(rdb1), 128'(e.rdb));
    end
  end

  initial begin
    int r;
    idle_defaults();
    s_rst[0] = 1; s_rst[1] = 1;
    apply();
    tick();
    tick();

    // Reset and load
    wr(0, OP_LOAD, 2, 'hA5);
    settle();
    chk("load_rda", 128'(rda0), 128'h A5);
    chk("load_rdb", 128'(rdb0), 128'h A5);
    chk("load_flat", 128'(flat0), 128'h00A5_0000);

    // Arithmetic wrap and ovf
    wr(0, OP_LOAD, 1, 'hF0);
    wr(0, OP_ADD, 1, 'h20);
    settle();
    chk("add_val", 128'(rda0), 128'h10);
    chk("add_ovf", 128'(ovf0), 128'h1);
    wr(0, OP_SUB, 1, 'h11);
    settle();
    chk("sub_val", 128'(rda0), 128'hFF);
    chk("sub_ovf", 128'(ovf0), 128'h1);
    wr(0, OP_INC, 1, 'h5A);
    settle();
    chk("inc_val", 128'(rda0), 128'h00);
    chk("inc_ovf", 128'(ovf0), 128'h1);
    wr(0, OP_LOAD, 1, 'h01);
    settle();
    chk("load_ovf", 128'(ovf0), 128'h0);

    // hold
    wr(0, OP_ADD, 1, 'hFF);
    wr(0, OP_LOAD, 0, 'h33);
    repeat (3) wr(0, OP_LOAD, 0, 'h77, 1'b1);
    settle();
    chk("hold_val", 128'(rda0), 128'h33);
    chk("hold_drop", 128'(drop0), 128'h0);

    // Bulk clear with a write issued mid-clear
    for (int i = 0; i < 4; i++) wr(0, OP_LOAD, i, 'h11 * (i + 1));
    s_clr[0] = 1;
    tick();
    tick();
    wr(0, OP_LOAD, 3, 'h55);
    settle();
    chk("clr_drop", 128'(drop0), 128'h1);
    chk("clr_busy", 128'(busy0), 128'h1);
    repeat (3) tick();

    // Reset mid-clear, then a full clear
    for (int i = 0; i < 4; i++) wr(0, OP_LOAD, i, 'h80 + i);
    s_clr[0] = 1;
    tick();
    repeat (2) tick();
    s_rst[0] = 1;
    tick();
    settle();
    chk("rst_busy", 128'(busy0), 128'h0);
    chk("rst_flat", 128'(flat0), 128'h0);
    for (int i = 0; i < 4; i++) wr(0, OP_LOAD, i, 'h40 + i);
    s_clr[0] = 1;
    tick();
    repeat (5) tick();

    // Wide instance
    wr(1, OP_LOAD, 7, 'hFFFF);
    wr(1, OP_INC, 7, 0);
    settle();
    chk("w16_inc_val", 128'(rda1), 128'h0);
    chk("w16_inc_ovf", 128'(ovf1), 128'h1);
    for (int i = 0; i < 8; i++) wr(1, OP_LOAD, i, 'h1000 + i);
    s_clr[1] = 1;
    tick();
    repeat (9) tick();

    // Randomized traffic on both instances
    repeat (600) begin
      for (int k = 0; k < 2; k++) begin
        r = $urandom_range(0, 99);
        s_rst[k]  = (r < 2);
        s_hold[k] = (r >= 2 && r < 10);
        s_clr[k]  = (r >= 10 && r < 15);
        s_wen[k]  = ($urandom_range(0, 9) < 6);
        s_op[k]   = $urandom_range(0, 3);
        s_wa[k]   = $urandom_range(0, D[k] - 1);
        s_wd[k]   = $urandom_range(0, 65535);
      end
      tick();
    end

    repeat (2) @(posedge clk);
    #1;
    chk("q0_drained", 128'(q0.size()), 128'h0);
    chk("q1_drained", 128'(q1.size()), 128'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_bank.md
# reg_bank

Parametrised general-purpose register bank for the datapath. It generalises the lab's 4×8 register store to DEPTH×WIDTH entries, with these additions:
- two independent read ports;
- a write port with an operation field (load, add, subtract, increment) and an overflow flag;
- a sequenced bulk-clear engine that zeroes one entry per cycle.

It sits between the instruction decode/ALU stage, which issues writes, and the display/output logic, which consumes the flat register image.

## Interface
Parameters:
- WIDTH, 8, bits per register (≥2)
- DEPTH, 4, number of registers (power of two, ≥2)
- ADDR_W, $clog2(DEPTH), address width (derived, not overridden)

Ports:
- clk  in  1  clock; all state updates on the falling edge
- reset  in  1  reset, synchronous, active-high
- hold  in  1  freezes all state (registers, flag, clear FSM) while high
- wr_en  in  1  write request, sampled each falling edge
- wr_op  in  2  write operation (encoding in Operation)
- wr_addr  in  ADDR_W  target register
- wr_data  in  WIDTH  write operand
- rd_addr_a  in  ADDR_W  read port A address
- rd_data_a  out  WIDTH  contents of rd_addr_a (combinational)
- rd_addr_b  in  ADDR_W  read port B address
- rd_data_b  out  WIDTH  contents of rd_addr_b (combinational)
- clr_start  in  1  starts a bulk clear
- busy  out  1  high while bulk clear runs
- ovf  out  1  carry/borrow of last accepted arithmetic write
- wr_drop  out  1  one-cycle pulse: a write was rejected
- regs_flat  out  DEPTH*WIDTH  all registers; entry i at bits [i*WIDTH +: WIDTH]

## Operation
- **wr_op encoding:**
  - OP_LOAD=00: reg ← wr_data.
  - OP_ADD=01: reg ← reg + wr_data.
  - OP_SUB=10: reg ← reg − wr_data.
  - OP_INC=11: reg ← reg + 1; wr_data is ignored.
- **Arithmetic width:** arithmetic is modulo 2^WIDTH. ovf is set to the carry-out (ADD/INC) or the borrow (SUB) of the accepted op. OP_LOAD clears ovf. ovf is unchanged when no write is accepted.
- **Read ports:** reads are purely combinational from stored state, with no write-through. A value written at an edge is visible only after that edge. Both ports may address the same entry.
- **Clear FSM states:** IDLE and CLEAR, with counter cnt (ADDR_W bits).
  - IDLE: clr_start=1 → CLEAR, with cnt=0.
  - CLEAR: each edge zeroes reg[cnt] and increments cnt. The edge that clears entry DEPTH−1 returns the FSM to IDLE.
  - busy = (state==CLEAR).
  - clr_start is ignored while in CLEAR.
- **Priority per edge:** reset > hold > CLEAR step > write.
- **Writes and the clear engine:**
  - A write with wr_en=1 is accepted only when hold=0 and the FSM is in IDLE and clr_start=0.
  - A write coinciding with clr_start, or arriving while busy, is dropped: wr_drop pulses for that cycle and ovf is unchanged.
- **hold:** no state changes while hold=1, and wr_drop stays 0. A write presented under hold is neither performed nor flagged.
- **reset:** all registers become 0, ovf=0, wr_drop=0, FSM goes to IDLE with cnt=0. This holds mid-clear as well; the clear is abandoned.

## Timing
- All state changes on negedge clk. Inputs must be stable around the falling edge.
- Write latency: the result is visible on regs_flat and the read ports immediately after the accepting edge.
- Bulk clear:
  - Takes exactly DEPTH edges.
  - busy rises after the edge that samples clr_start, and falls after the edge that clears entry DEPTH−1.
  - The first write that can be accepted is at the edge after busy falls.
- wr_drop and ovf are registered and update on the same edge as the write decision.
- Reset values: every register 0, regs_flat 0, rd_data_a/b 0, busy 0, ovf 0, wr_drop 0.

## Structure
- Package reg_bank_pkg: the wr_op encodings (OP_LOAD, OP_ADD, OP_SUB, OP_INC) and the FSM state type/encoding (ST_IDLE, ST_CLEAR).
- One sub-module, reg_bank_clr_fsm: owns the state and cnt. Inputs are clk, reset, hold and clr_start; outputs are busy, clr_en and clr_addr.
- The top level holds the storage array, the arithmetic unit with carry, the accept/drop logic, the read muxes and the flattening of regs_flat.

## Test plan
- **Reset and load:** reset, then OP_LOAD 8'hA5 to r2, read both ports at r2 → rd_data_a=rd_data_b=8'hA5, regs_flat[23:16]=8'hA5, others 0.
- **Arithmetic wrap and ovf:**
  - r1=8'hF0, then OP_ADD 8'h20 → r1=8'h10, ovf=1.
  - OP_SUB 8'h11 → r1=8'hFF, ovf=1.
  - OP_INC → r1=8'h00, ovf=1.
  - OP_LOAD 8'h01 → ovf=0.
- **hold:** r0=8'h33, then hold=1 with OP_LOAD 8'h77 to r0 for 3 edges → r0 stays 8'h33, wr_drop=0, ovf unchanged.
- **Bulk clear with a blocked write:**
  - Load all entries nonzero, then pulse clr_start → busy high for exactly 4 edges, regs zero in order r0..r3.
  - A write issued mid-clear → wr_drop=1 for that cycle, no change to the target register.
- **Reset mid-clear:** reset asserted after 2 clear steps → busy=0 next edge, all regs 0, cnt=0. A following clr_start runs a full 4-step clear.
- **Parametrised instance:** WIDTH=16, DEPTH=8: load r7=16'hFFFF, OP_INC → 0 with ovf=1. A bulk clear takes 8 edges.
